seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
- Multiplexed driver for the board's 4-digit common-anode 7-segment display.
- Drives the `abcdefgh` and `digit` pins that the lab `top` modules currently tie off to all-off.
- Takes a 16-bit hex value plus decimal points, scans one digit at a time with an inter-digit guard blank, and applies new values only at frame boundaries via a load/ready handshake.

Parameters:
- DIGIT_PERIOD, default 50000: clock cycles each digit slot lasts. Must be >= GUARD+2.
- GUARD, default 2: cycles at the start of each slot with all digits deselected (anti-ghosting). Must be >= 0.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- number, input, 16: four hex nibbles. Digit 0 = bits 3:0 (rightmost); digit 3 = bits 15:12.
- dots, input, 4: decimal point per digit; bit i belongs to digit i.
- digit_en, input, 4: per-digit enable; 0 blanks that digit completely.
- blank_lz, input, 1: 1 enables leading-zero suppression.
- load, input, 1: request to capture number/dots/digit_en/blank_lz.
- ready, output, 1: high when a load will be accepted.
- abcdefgh, output, 8: segment drive, active-low. Bit 7 = a, bit 1 = g, bit 0 = h (dp).
- digit, output, 4: digit select, active-low one-hot; bit i = digit i.
- frame_done, output, 1: one-cycle pulse at the end of each full 4-digit frame.

Behaviour:
- One clock. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - abcdefgh = 8'hFF, digit = 4'hF, ready = 1, frame_done = 0.
  - Active and pending registers, slot counter cnt and slot index idx all cleared to 0.
  - Active digit_en = 0, so the display stays blank until the first load is applied.
  - Reset asserted mid-frame forces all outputs to these values immediately, with no clock edge.
- Scan timing:
  - cnt runs 0..DIGIT_PERIOD-1.
  - At terminal count, cnt wraps to 0 and idx advances 0→1→2→3→0.
  - Frame length is 4*DIGIT_PERIOD cycles.
- frame_done is high exactly in the terminal-count cycle of slot 3.
- Outputs are registered and lag idx/cnt by 1 cycle.
- Digit select within a slot:
  - For cnt < GUARD: digit = 4'hF.
  - Otherwise: digit bit idx = 0 if active digit_en[idx] = 1; else digit = 4'hF.
- Hex decode (segments lit, active-high before inversion):
  - 0: abcdef; 1: bc; 2: abdeg; 3: abcdg; 4: bcfg; 5: acdfg; 6: acdefg; 7: abc.
  - 8: abcdefg; 9: abcdfg; A: abcefg; b: cdefg; C: adef; d: bcdeg; E: adefg; F: aefg.
  - h = dots[idx]. abcdefgh = ~{a,b,c,d,e,f,g,h}.
- Leading-zero suppression (active blank_lz = 1):
  - Digit i (i = 3, 2, 1) has segments a–g forced off if its nibble and every higher-index nibble are 0.
  - Digit 0 is never suppressed.
  - dp still follows dots.
  - digit select is unaffected by suppression.
- When no digit is selected (guard cycles or disabled digit), abcdefgh = 8'hFF.
- Handshake:
  - If load = 1 and ready = 1, inputs are captured into pending registers and ready goes 0 on the next cycle.
  - load while ready = 0 is ignored; the pending value is not overwritten.
  - On the frame_done cycle with an update pending, active <= pending. ready returns to 1 on the following cycle.
  - If a load is accepted on the frame_done cycle itself, it applies at the next frame end, not the current one.
  - With no update pending, active is unchanged at frame end.
- Width rules:
  - cnt is $clog2(DIGIT_PERIOD) bits wide; idx is 2 bits and wraps naturally.
  - No arithmetic is performed on display data.

Test Plan (DIGIT_PERIOD = 8, GUARD = 2 unless stated):
1. Reset: hold reset_n = 0 → abcdefgh = 8'hFF, digit = 4'hF, ready = 1, frame_done = 0. Release with no load → output stays blank for 3 frames while frame_done pulses every 32 cycles.
2. Load number = 16'h12AF, dots = 4'b0001, digit_en = 4'hF, blank_lz = 0 → after the next frame_done, each slot shows:
   - digit 0 (digit = 4'b1110): abcdefgh = 8'h70
   - digit 1: 8'h11
   - digit 2: 8'h25
   - digit 3: 8'h9F
3. Guard and scan timing: in steady state, the first 2 output cycles of every slot have digit = 4'hF and the remaining 6 have one bit low. Selects rotate 1110→1101→1011→0111.
4. Leading zero: number = 16'h0040, blank_lz = 1, dots = 0, digit_en = 4'hF →
   - digits 3 and 2: abcdefgh = 8'hFF (select still asserted)
   - digit 1: 8'h99
   - digit 0: 8'h03
   - Same value with blank_lz = 0 → digits 3 and 2 show 8'h03.
5. Handshake:
   - Load A → ready = 0 next cycle.
   - Load B while ready = 0 → ignored.
   - At frame_done, A is displayed from the next slot; ready = 1 one cycle later.
   - Load on the frame_done cycle itself → takes effect one frame later.
6. Reset mid-frame while displaying 16'h8888: drop reset_n between clock edges → abcdefgh = 8'hFF, digit = 4'hF immediately. After release the display stays blank until a new load is applied.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Multiplexed driver for a 4-digit common-anode 7-segment display.
// Scans one digit per slot with a leading guard blank; new values are
// taken through a load/ready handshake and applied only at frame end.
module seven_segment_scanner #(
    parameter int unsigned DIGIT_PERIOD = 50000,
    parameter int unsigned GUARD        = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] number,
    input  logic [3:0]  dots,
    input  logic [3:0]  digit_en,
    input  logic        blank_lz,
    input  logic        load,
    output logic        ready,
    output logic [7:0]  abcdefgh,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int unsigned CNT_W = $clog2(DIGIT_PERIOD);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;

    logic [15:0] act_number;
    logic [3:0]  act_dots;
    logic [3:0]  act_en;
    logic        act_lz;

    logic [15:0] pend_number;
    logic [3:0]  pend_dots;
    logic [3:0]  pend_en;
    logic        pend_lz;

    logic        tc_c;
    logic        pre_frame_end_c;
    logic        in_guard_c;
    logic [3:0]  nib_c [4];
    logic [3:0]  supp_c;
    logic        sel_c;
    logic [6:0]  segs_c;
    logic [7:0]  seg_out_c;
    logic [3:0]  dig_out_c;

    // Hex nibble to segments a..g, active-high (bit 6 = a, bit 0 = g).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    // Slot timing decodes: terminal count, and the cycle just before frame end.
    assign tc_c            = (cnt == CNT_W'(DIGIT_PERIOD - 1));
    assign pre_frame_end_c = (cnt == CNT_W'(DIGIT_PERIOD - 2)) && (idx == 2'd3);

    // Guard window at the start of each slot (absent when GUARD is zero).
    if (GUARD == 0) begin : g_no_guard
        assign in_guard_c = 1'b0;
    end else begin : g_guard
        assign in_guard_c = (cnt < CNT_W'(GUARD));
    end

    // Slot counter and digit index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tc_c) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Load/ready handshake: capture into pending, promote at frame end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready       <= 1'b1;
            pend_number <= '0;
            pend_dots   <= '0;
            pend_en     <= '0;
            pend_lz     <= 1'b0;
            act_number  <= '0;
            act_dots    <= '0;
            act_en      <= '0;
            act_lz      <= 1'b0;
        end else if (load && ready) begin
            pend_number <= number;
            pend_dots   <= dots;
            pend_en     <= digit_en;
            pend_lz     <= blank_lz;
            ready       <= 1'b0;
        end else if (frame_done && !ready) begin
            act_number <= pend_number;
            act_dots   <= pend_dots;
            act_en     <= pend_en;
            act_lz     <= pend_lz;
            ready      <= 1'b1;
        end
    end

    // Nibble split and leading-zero suppression flags (digit 0 never suppressed).
    always_comb begin
        nib_c[0]  = act_number[3:0];
        nib_c[1]  = act_number[7:4];
        nib_c[2]  = act_number[11:8];
        nib_c[3]  = act_number[15:12];
        supp_c    = 4'b0000;
        supp_c[3] = act_lz && (nib_c[3] == 4'h0);
        supp_c[2] = supp_c[3] && (nib_c[2] == 4'h0);
        supp_c[1] = supp_c[2] && (nib_c[1] == 4'h0);
    end

    // Next segment/select values for the current slot and count.
    always_comb begin
        sel_c     = !in_guard_c && act_en[idx];
        segs_c    = supp_c[idx] ? 7'h00 : hex_to_seg(nib_c[idx]);
        seg_out_c = 8'hFF;
        dig_out_c = 4'hF;
        if (sel_c) begin
            seg_out_c = ~{segs_c, act_dots[idx]};
            dig_out_c = ~(4'(1) << idx);
        end
    end

    // Registered display outputs and frame-end pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            abcdefgh   <= 8'hFF;
            digit      <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            abcdefgh   <= seg_out_c;
            digit      <= dig_out_c;
            frame_done <= pre_frame_end_c;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with DIGIT_PERIOD = 8, GUARD = 2.
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] number;
    logic [3:0]  dots;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic        load;
    logic        ready;
    logic [7:0]  abcdefgh;
    logic [3:0]  digit;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0]     number;
        logic [3:0]      dots;
        logic [3:0]      en;
        logic            lz;
        logic [3:0][7:0] seg;   // expected abcdefgh per digit index
    } vec_t;

    vec_t vecs [6];
    vec_t va;
    vec_t vb;
    vec_t v8;

    seven_segment_scanner #(.DIGIT_PERIOD(8), .GUARD(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .number     (number),
        .dots       (dots),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .load       (load),
        .ready      (ready),
        .abcdefgh   (abcdefgh),
        .digit      (digit),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; presents v and holds load for one posedge.
    task automatic do_load(input vec_t v);
        check("ready_before_load", 8'(ready), 8'h01);
        number   = v.number;
        dots     = v.dots;
        digit_en = v.en;
        blank_lz = v.lz;
        load     = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        check("ready_after_load", 8'(ready), 8'h00);
    endtask

    // Advance negedge by negedge until frame_done is seen (bounded).
    task automatic wait_fd();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL wait_frame_done: got timeout expected pulse within 100 cycles");
    endtask

    // Starts at the negedge of a frame_done cycle; checks one full frame and
    // ends at the negedge of the next frame_done cycle.
    task automatic scan_check(input vec_t v, input logic exp_ready, input string tag);
        int slot;
        int c;
        logic [3:0] exp_dig;
        logic [7:0] exp_seg;
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            if (j == 0) check({tag, "_ready"}, 8'(ready), 8'(exp_ready));
            if (j >= 1) begin
                slot = (j - 1) / 8;
                c    = (j - 1) % 8;
                if (c < 2 || !v.en[slot]) begin
                    exp_dig = 4'hF;
                    exp_seg = 8'hFF;
                end else begin
                    exp_dig = ~(4'(1) << slot);
                    exp_seg = v.seg[slot];
                end
                check({tag, "_digit"}, 8'(digit), 8'(exp_dig));
                check({tag, "_seg"}, abcdefgh, exp_seg);
            end
            check({tag, "_frame_done"}, 8'(frame_done), (j == 31) ? 8'h01 : 8'h00);
        end
    endtask

    // Starts at the negedge where reset_n was released; display must stay blank.
    task automatic blank_frames(input int frames, input string tag);
        for (int k = 1; k <= frames * 32; k++) begin
            @(negedge clk);
            check({tag, "_digit"}, 8'(digit), 8'h0F);
            check({tag, "_seg"}, abcdefgh, 8'hFF);
            check({tag, "_frame_done"}, 8'(frame_done), (k % 32 == 31) ? 8'h01 : 8'h00);
            check({tag, "_ready"}, 8'(ready), 8'h01);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h12AF, 4'b0001, 4'hF, 1'b0, {8'h9F, 8'h25, 8'h11, 8'h70}};
        vecs[1] = '{16'h0040, 4'b0000, 4'hF, 1'b1, {8'hFF, 8'hFF, 8'h99, 8'h03}};
        vecs[2] = '{16'h0040, 4'b0000, 4'hF, 1'b0, {8'h03, 8'h03, 8'h99, 8'h03}};
        vecs[3] = '{16'h8888, 4'b1111, 4'b0101, 1'b0, {8'hFF, 8'h00, 8'hFF, 8'h00}};
        vecs[4] = '{16'h0000, 4'b1010, 4'hF, 1'b1, {8'hFE, 8'hFF, 8'hFE, 8'h03}};
        vecs[5] = '{16'h0305, 4'b0000, 4'hF, 1'b1, {8'hFF, 8'h0D, 8'h03, 8'h49}};
        va = '{16'h1111, 4'b0000, 4'hF, 1'b0, {8'h9F, 8'h9F, 8'h9F, 8'h9F}};
        vb = '{16'h2222, 4'b0000, 4'hF, 1'b0, {8'h25, 8'h25, 8'h25, 8'h25}};
        v8 = '{16'h8888, 4'b0000, 4'hF, 1'b0, {8'h01, 8'h01, 8'h01, 8'h01}};

        reset_n  = 1'b0;
        number   = '0;
        dots     = '0;
        digit_en = '0;
        blank_lz = 1'b0;
        load     = 1'b0;

        // Reset values, then blank display with periodic frame_done.
        #23;
        check("rst_seg", abcdefgh, 8'hFF);
        check("rst_digit", 8'(digit), 8'h0F);
        check("rst_ready", 8'(ready), 8'h01);
        check("rst_frame_done", 8'(frame_done), 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        blank_frames(3, "blank_after_reset");

        // Table of display patterns.
        for (int i = 0; i < 6; i++) begin
            do_load(vecs[i]);
            wait_fd();
            scan_check(vecs[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Load A, then B while busy: B must be dropped.
        repeat (5) @(negedge clk);
        do_load(va);
        @(negedge clk);
        number = vb.number;
        load   = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        check("busy_load_ready", 8'(ready), 8'h00);
        wait_fd();
        check("fd_ready_pending", 8'(ready), 8'h00);
        scan_check(va, 1'b1, "hs_a");

        // Load accepted on the frame_done cycle applies one frame later.
        do_load(vecs[0]);
        scan_check(va, 1'b0, "fd_load_old");
        scan_check(vecs[0], 1'b1, "fd_load_new");

        // Asynchronous reset in the middle of a frame.
        do_load(v8);
        wait_fd();
        scan_check(v8, 1'b1, "pre_rst");
        repeat (12) @(negedge clk);
        check("mid_digit", 8'(digit), 8'h0D);
        check("mid_seg", abcdefgh, 8'h01);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_seg", abcdefgh, 8'hFF);
        check("async_rst_digit", 8'(digit), 8'h0F);
        check("async_rst_ready", 8'(ready), 8'h01);
        check("async_rst_frame_done", 8'(frame_done), 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        blank_frames(2, "blank_after_mid_rst");
        do_load(vecs[5]);
        wait_fd();
        scan_check(vecs[5], 1'b1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
